// File: rtl/muldiv_if.sv
// Pipeline <-> multiply/divide unit bundle: operand issue, flush, stall feedback and HI/LO.
// master = E-stage pipeline side, slave = muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rs, rt, flush,
    input  start, busy, hi, lo
  );

  modport slave (
    input  op_valid, op, rs, rt, flush,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with flush abort and defined div corner cases.
// Optional feature: define MULDIV_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int W2         = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic [CW-1:0]    cnt_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] rs_reg;
  logic [WIDTH-1:0] rt_reg;

  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic accept;
  logic start;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (bus.op)
      OP_MULT, OP_MULTU: is_mul  = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU: is_mul  = 1'b1;
`endif
      OP_DIV, OP_DIVU:   is_div  = 1'b1;
      OP_MTHI:           is_mthi = 1'b1;
      OP_MTLO:           is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign accept = reset & bus.op_valid & ~bus.flush & ~busy_reg;
  assign start  = accept & (is_mul | is_div);

  // Datapath works only on captured operands; the busy window exists so it can be
  // constrained as a multicycle path.
  logic             op_signed;
  logic             op_is_div;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    mul_res;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_comb begin
    op_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);
`ifdef MULDIV_MADD_EN
    op_signed = op_signed || (op_reg == OP_MADD) || (op_reg == OP_MSUB);
`endif
    op_is_div = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  end

  // Sign/zero-extending to 2*WIDTH makes the low 2*WIDTH product bits exact for both flavours.
  always_comb begin
    a_ext = op_signed ? {{WIDTH{rs_reg[WIDTH-1]}}, rs_reg} : {{WIDTH{1'b0}}, rs_reg};
    b_ext = op_signed ? {{WIDTH{rt_reg[WIDTH-1]}}, rt_reg} : {{WIDTH{1'b0}}, rt_reg};
    prod  = a_ext * b_ext;
    mul_res = prod;
`ifdef MULDIV_MADD_EN
    case (op_reg)
      OP_MADD, OP_MADDU: mul_res = {hi_reg, lo_reg} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_reg, lo_reg} - prod;
      default: ;
    endcase
`endif
  end

  // Magnitude divide; -2^(W-1)/-1 wraps back to -2^(W-1) with remainder 0 naturally.
  always_comb begin
    neg_a    = op_signed & rs_reg[WIDTH-1];
    neg_b    = op_signed & rt_reg[WIDTH-1];
    abs_a    = neg_a ? -rs_reg : rs_reg;
    abs_b    = neg_b ? -rt_reg : rt_reg;
    div_zero = (rt_reg == '0);
    den      = div_zero ? WIDTH'(1) : abs_b;
    q_mag    = abs_a / den;
    r_mag    = abs_a % den;
    quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem      = neg_a ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (busy_reg) begin
      if (bus.flush) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else if (cnt_reg == '0) begin
        busy_reg <= 1'b0;
        if (op_is_div) begin
          if (!div_zero) begin
            hi_reg <= rem;
            lo_reg <= quot;
          end
        end else begin
          {hi_reg, lo_reg} <= mul_res;
        end
      end else begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= is_div ? DIV_LOAD : MULT_LOAD;
      op_reg   <= bus.op;
      rs_reg   <= bus.rs;
      rt_reg   <= bus.rt;
    end else if (accept && is_mthi) begin
      hi_reg <= bus.rs;
    end else if (accept && is_mtlo) begin
      lo_reg <= bus.rs;
    end
  end

  assign bus.start = start;
  assign bus.busy  = busy_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
endmodule
